// File: rtl/wb_cfg_arbiter.sv
// Two-requester round-robin arbiter driving a single Wishbone classic master port
// for a 1K-word configuration space, with per-transaction ack/err/timeout reporting.
module wb_cfg_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [31:0] adr0_i,
    input  logic [3:0]  sel0_i,
    input  logic [31:0] dat0_i,
    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [31:0] adr1_i,
    input  logic [3:0]  sel1_i,
    input  logic [31:0] dat1_i,
    output logic        done0_o,
    output logic [31:0] rdat0_o,
    output logic        err0_o,
    output logic        to0_o,
    output logic        done1_o,
    output logic [31:0] rdat1_o,
    output logic        err1_o,
    output logic        to1_o,
    output logic [9:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        gnt;       // requester owning the current transaction
    logic        last_gnt;  // requester granted most recently
    logic [15:0] wait_cnt;

    logic        grant_sel;
    logic        sel_we;
    logic [31:0] sel_adr;
    logic [3:0]  sel_sel;
    logic [31:0] sel_dat;
    logic        term;
    logic        is_err;
    logic        is_to;
    logic        unused_adr_bits;

    // Under contention the requester not served last wins; a lone request always wins.
    assign grant_sel = (req0_i && req1_i) ? ~last_gnt : req1_i;
    assign sel_we    = grant_sel ? we1_i  : we0_i;
    assign sel_adr   = grant_sel ? adr1_i : adr0_i;
    assign sel_sel   = grant_sel ? sel1_i : sel0_i;
    assign sel_dat   = grant_sel ? dat1_i : dat0_i;

    // A slave response on the final wait cycle counts as a response, not a timeout.
    assign term   = wb_ack_i || wb_err_i || (wait_cnt == WAIT_LAST);
    assign is_err = wb_err_i || !wb_ack_i;
    assign is_to  = !wb_err_i && !wb_ack_i;

    assign busy_o = (state != IDLE);

    assign unused_adr_bits = ^{sel_adr[31:12], sel_adr[1:0]};

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            wait_cnt <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            done0_o  <= 1'b0;
            err0_o   <= 1'b0;
            to0_o    <= 1'b0;
            rdat0_o  <= '0;
            done1_o  <= 1'b0;
            err1_o   <= 1'b0;
            to1_o    <= 1'b0;
            rdat1_o  <= '0;
        end else begin
            // Completion flags are single-cycle pulses by default.
            done0_o <= 1'b0;
            err0_o  <= 1'b0;
            to0_o   <= 1'b0;
            done1_o <= 1'b0;
            err1_o  <= 1'b0;
            to1_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        gnt      <= grant_sel;
                        last_gnt <= grant_sel;
                        wb_we_o  <= sel_we;
                        wb_adr_o <= sel_adr[11:2];
                        wb_sel_o <= sel_sel;
                        wb_dat_o <= sel_we ? sel_dat : 32'h0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RESP;
                        if (gnt) begin
                            done1_o <= 1'b1;
                            err1_o  <= is_err;
                            to1_o   <= is_to;
                            if (wb_ack_i && !wb_err_i && !wb_we_o) rdat1_o <= wb_dat_i;
                        end else begin
                            done0_o <= 1'b1;
                            err0_o  <= is_err;
                            to0_o   <= is_to;
                            if (wb_ack_i && !wb_err_i && !wb_we_o) rdat0_o <= wb_dat_i;
                        end
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
